// File: rtl/iram_axil.sv
// Dual-port instruction RAM: registered fetch port A with reset-vector priming,
// AXI4-Lite slave on port B with SLVERR for out-of-window accesses.
module iram_axil #(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] RST_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_n_i,
    input  logic        iram_rd_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        fetch_err_o,
    output logic        iram_rstn_o,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] WIN_BYTES = 33'(DEPTH) << 2;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [1:0]  RESP_OK   = 2'b00;
    localparam logic [1:0]  RESP_SLV  = 2'b10;

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE_ADDR) && ({1'b0, a - BASE_ADDR} < WIN_BYTES);
    endfunction

    function automatic logic [AW-1:0] idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem [DEPTH];
    logic [31:0] ram_a_q;
    logic [31:0] ram_b_q;
    logic        rd_ok;
    logic        prio_rd;
    logic        wr_elig;
    logic        rd_elig;
    logic        grant_w;
    logic        grant_r;
    logic        fetch_en;
    logic [31:0] fetch_addr;
    logic        unused;

    assign unused = ^{awprot, arprot};

    // Readies depend only on valids, response state and the arbiter pointer.
    always_comb begin
        wr_elig = awvalid & wvalid & (~bvalid | bready);
        rd_elig = arvalid & (~rvalid | rready);
        grant_w = wr_elig & (~rd_elig | ~prio_rd);
        grant_r = rd_elig & (~wr_elig | prio_rd);
    end

    assign awready = grant_w;
    assign wready  = grant_w;
    assign arready = grant_r;

    assign fetch_en   = iram_rstn_o | iram_rd_i;
    assign fetch_addr = iram_rstn_o ? RST_PC : pc_n_i;

    // RAM array has no reset so it maps onto block RAM; both reads are read-first.
    always_ff @(posedge clk) begin
        if (fetch_en) begin
            ram_a_q <= mem[idx(fetch_addr)];
        end
        if (grant_r) begin
            ram_b_q <= mem[idx(araddr)];
        end
        if (grant_w && in_range(awaddr)) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx(awaddr)][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iram_rstn_o <= 1'b1;
            pc_o        <= RST_PC;
            fetch_err_o <= ~in_range(RST_PC);
        end else begin
            iram_rstn_o <= 1'b0;
            if (iram_rstn_o) begin
                pc_o        <= RST_PC;
                fetch_err_o <= ~in_range(RST_PC);
            end else if (iram_rd_i) begin
                pc_o        <= pc_n_i;
                fetch_err_o <= ~in_range(pc_n_i);
            end
        end
    end

    assign inst_o = fetch_err_o ? NOP : ram_a_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid  <= 1'b0;
            bresp   <= RESP_OK;
            rvalid  <= 1'b0;
            rresp   <= RESP_OK;
            rd_ok   <= 1'b0;
            prio_rd <= 1'b0;
        end else begin
            if (grant_w) begin
                bvalid  <= 1'b1;
                bresp   <= in_range(awaddr) ? RESP_OK : RESP_SLV;
                prio_rd <= 1'b1;
            end else if (bready) begin
                bvalid <= 1'b0;
            end
            if (grant_r) begin
                rvalid  <= 1'b1;
                rresp   <= in_range(araddr) ? RESP_OK : RESP_SLV;
                rd_ok   <= in_range(araddr);
                prio_rd <= 1'b0;
            end else if (rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // rd_ok masks the unreset RAM output so rdata is zero after reset and on SLVERR.
    assign rdata = rd_ok ? ram_b_q : 32'h0;

endmodule

// File: tb/tb_iram_axil.sv
// Directed bench for iram_axil: reset/priming, AXI strobes and backpressure,
// out-of-range SLVERR, arbitration, fetch/write collision and mid-transaction reset.
module tb_iram_axil;
    localparam int          DEPTH  = 256;
    localparam logic [31:0] RST_PC = 32'h0000_0080;
    localparam int K_WR = 0;
    localparam int K_RD = 1;
    localparam int K_FE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_n_i = '0;
    logic        iram_rd_i = 1'b0;
    logic [31:0] pc_o, inst_o;
    logic        fetch_err_o, iram_rstn_o;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t vecs[$];

    iram_axil #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .RST_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .pc_n_i(pc_n_i), .iram_rd_i(iram_rd_i),
        .pc_o(pc_o), .inst_o(inst_o), .fetch_err_o(fetch_err_o), .iram_rstn_o(iram_rstn_o),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reset_pulse();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b0; rready = 1'b0; iram_rd_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Driver tasks: start and end on a falling edge.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit ok = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        resp = 2'b11;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (awready && wready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        if (!ok) check("wr_accept_timeout", 32'(ok), 32'd1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bvalid) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) check("bvalid_timeout", 32'(ok), 32'd1);
        resp = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit ok = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        d = 'x; resp = 2'b11;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (arready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        arvalid = 1'b0;
        if (!ok) check("rd_accept_timeout", 32'(ok), 32'd1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (rvalid) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) check("rvalid_timeout", 32'(ok), 32'd1);
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        pc_n_i = a; iram_rd_i = 1'b1;
        @(negedge clk);
        iram_rd_i = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        int          nw, nr;

        vecs.push_back('{K_WR, 32'h000, 32'h1234_5678, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{K_RD, 32'h000, 32'h0, 4'h0, 32'h1234_5678, 2'b00});
        vecs.push_back('{K_WR, 32'h400, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10});
        vecs.push_back('{K_RD, 32'h400, 32'h0, 4'h0, 32'h0, 2'b10});
        vecs.push_back('{K_RD, 32'h000, 32'h0, 4'h0, 32'h1234_5678, 2'b00});
        vecs.push_back('{K_WR, 32'hFFFF_FFFC, 32'h1111_1111, 4'hF, 32'h0, 2'b10});
        vecs.push_back('{K_RD, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0, 2'b10});
        vecs.push_back('{K_WR, 32'h3FC, 32'h0BAD_F00D, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{K_RD, 32'h3FC, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00});
        vecs.push_back('{K_FE, 32'h3FC, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00});
        vecs.push_back('{K_FE, 32'h400, 32'h0, 4'h0, 32'h0000_0013, 2'b01});
        vecs.push_back('{K_WR, 32'h004, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b00});
        vecs.push_back('{K_WR, 32'h004, 32'hAB00_0000, 4'h8, 32'h0, 2'b00});
        vecs.push_back('{K_RD, 32'h004, 32'h0, 4'h0, 32'hABFF_FFFF, 2'b00});
        vecs.push_back('{K_FE, 32'h010, 32'h0, 4'h0, 32'hAA22_AA44, 2'b00});
        vecs.push_back('{K_WR, 32'h100, 32'h0000_0000, 4'hF, 32'h0, 2'b00});

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_iram_rstn", 32'(iram_rstn_o), 32'd1);
        check("rst_pc", pc_o, RST_PC);
        check("rst_fetch_err", 32'(fetch_err_o), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", 32'({bresp, rresp}), 32'd0);
        rst_n = 1'b1;

        // Preload the reset vector word, then re-prime from reset
        @(negedge clk);
        axi_write(RST_PC, 32'hDEAD_BEEF, 4'hF, resp);
        check("preload_bresp", 32'(resp), 32'd0);
        reset_pulse();
        @(negedge clk);
        check("prime1_rstn", 32'(iram_rstn_o), 32'd0);
        check("prime1_pc", pc_o, RST_PC);
        check("prime1_inst", inst_o, 32'hDEAD_BEEF);
        @(negedge clk);
        check("prime2_rstn", 32'(iram_rstn_o), 32'd0);
        check("prime2_pc", pc_o, RST_PC);
        check("prime2_inst", inst_o, 32'hDEAD_BEEF);

        // Strobed write with B backpressure; second write must stall
        axi_write(32'h10, 32'hAAAA_AAAA, 4'hF, resp);
        awaddr = 32'h10; wdata = 32'h1122_3344; wstrb = 4'b0101;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        #1 check("bp_accept", 32'(awready & wready), 32'd1);
        @(negedge clk);
        awaddr = 32'h14; wdata = 32'h9999_9999; wstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_bvalid", 32'(bvalid), 32'd1);
            check("bp_bresp", 32'(bresp), 32'd0);
            check("bp_blocked", 32'(awready), 32'd0);
            @(negedge clk);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bp_bvalid_clr", 32'(bvalid), 32'd0);
        fetch(32'h10);
        check("bp_fetch", inst_o, 32'hAA22_AA44);

        // Vector table
        foreach (vecs[i]) begin
            case (vecs[i].kind)
                K_WR: begin
                    axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                    check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                end
                K_RD: begin
                    axi_read(vecs[i].addr, d, resp);
                    check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
                    check($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                end
                default: begin
                    fetch(vecs[i].addr);
                    check($sformatf("vec%0d_pc", i), pc_o, vecs[i].addr);
                    check($sformatf("vec%0d_inst", i), inst_o, vecs[i].exp_data);
                    check($sformatf("vec%0d_ferr", i), 32'(fetch_err_o), 32'(vecs[i].exp_resp[0]));
                end
            endcase
        end

        // Fetch and AXI write to the same word in one cycle: read-first
        pc_n_i = 32'h100; iram_rd_i = 1'b1;
        awaddr = 32'h100; wdata = 32'h5555_5555; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1 check("coll_accept", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("coll_old", inst_o, 32'h0);
        check("coll_pc", pc_o, 32'h100);
        @(negedge clk);
        iram_rd_i = 1'b0; bready = 1'b0;
        check("coll_new", inst_o, 32'h5555_5555);

        // Arbitration from a fresh pointer
        reset_pulse();
        awaddr = 32'h200; wdata = 32'hCAFE_0000; wstrb = 4'hF;
        araddr = RST_PC;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        nw = 0; nr = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (awready) nw++;
            if (arready) nr++;
            check($sformatf("arb%0d_w", i), 32'(awready), 32'(i % 2 == 0));
            check($sformatf("arb%0d_r", i), 32'(arready), 32'(i % 2 == 1));
            if (i == 2) begin
                check("arb_rvalid", 32'(rvalid), 32'd1);
                check("arb_rdata", rdata, 32'hDEAD_BEEF);
            end
            @(negedge clk);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("arb_writes", 32'(nw), 32'd4);
        check("arb_reads", 32'(nr), 32'd4);
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;

        // Reset while a read response is stalled
        araddr = RST_PC; arvalid = 1'b1; rready = 1'b0;
        #1 check("mr_accept", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("mr_rvalid", 32'(rvalid), 32'd1);
        check("mr_rdata", rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("mr_hold", rdata, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        check("mr_rvalid_drop", 32'(rvalid), 32'd0);
        check("mr_rdata_zero", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_pc", pc_o, RST_PC);
        check("mr_inst", inst_o, 32'hDEAD_BEEF);
        axi_read(32'h10, d, resp);
        check("mr_ram_kept", d, 32'hAA22_AA44);
        check("mr_rresp", 32'(resp), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
